// File: rtl/dkong_bus_arb.sv
// rtl/dkong_bus_arb.sv - Z80 / dual-DMA shared bus arbiter with BUSRQ/BUSAK handshake
//
// Purpose:
//   Hands the shared CPU address/data bus to one of two DMA masters.
//   Channel 0 is the sprite DMA and has fixed priority. Channel 1 is the
//   auxiliary DMA. A hold request is turned into a Z80 BUSRQ, and HLDA is
//   returned once BUSAK is seen. After each grant the CPU keeps the bus for
//   a guaranteed window before the next BUSRQ can be issued.
//
// Ports:
//   I_CLK       system clock
//   I_RST       synchronous active-high reset (honoured regardless of I_CLK_EN)
//   I_CLK_EN    clock enable; state advances only on enabled edges
//   I_HRQ0      hold request, channel 0 (sprite DMA)
//   I_HRQ1      hold request, channel 1 (aux DMA)
//   I_BUSAK_n   Z80 bus acknowledge, active-low
//   O_BUSRQ_n   Z80 bus request, active-low
//   O_HLDA0     hold acknowledge, channel 0
//   O_HLDA1     hold acknowledge, channel 1
//   O_SEL       bus mux select: 00 CPU, 01 ch0, 10 ch1
//   O_BUSY      arbiter is not idle
//   O_ERR       sticky BUSAK timeout flag, cleared only by reset

module dkong_bus_arb #(
  parameter int CPU_GAP     = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic       I_CLK_EN,
  input  logic       I_HRQ0,
  input  logic       I_HRQ1,
  input  logic       I_BUSAK_n,
  output logic       O_BUSRQ_n,
  output logic       O_HLDA0,
  output logic       O_HLDA1,
  output logic [1:0] O_SEL,
  output logic       O_BUSY,
  output logic       O_ERR
);

  // Gap counter only needs to hold CPU_GAP; keep at least one bit so the
  // declaration stays legal when the gap is disabled.
  localparam int GAP_W = (CPU_GAP > 0) ? $clog2(CPU_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(CPU_GAP);
  localparam logic [7:0]       TMO_LIMIT = 8'(ACK_TIMEOUT);

  localparam logic [1:0] SEL_CPU = 2'b00;
  localparam logic [1:0] SEL_CH0 = 2'b01;
  localparam logic [1:0] SEL_CH1 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_GRANT0  = 3'd2,
    S_GRANT1  = 3'd3,
    S_RELEASE = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d, tmo_inc;
  logic [GAP_W-1:0] gap_q, gap_d, gap_dec;
  logic             busrq_n_q, busrq_n_d;
  logic             hlda0_q, hlda0_d;
  logic             hlda1_q, hlda1_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  // Saturating increment / floor-at-zero decrement helpers.
  assign tmo_inc = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
  assign gap_dec = (gap_q == '0) ? gap_q : gap_q - GAP_W'(1);

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    busrq_n_d = busrq_n_q;
    hlda0_d   = hlda0_q;
    hlda1_d   = hlda1_q;
    sel_d     = sel_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (I_HRQ0 || I_HRQ1) begin
          state_d   = S_REQ;
          busrq_n_d = 1'b0;
          tmo_d     = '0;
        end
      end

      S_REQ: begin
        // Winner is picked from the HRQ values seen on the same edge as
        // BUSAK, so a late-arriving ch0 still beats a waiting ch1.
        if (!I_BUSAK_n && I_HRQ0) begin
          state_d = S_GRANT0;
          hlda0_d = 1'b1;
          sel_d   = SEL_CH0;
        end else if (!I_BUSAK_n && I_HRQ1) begin
          state_d = S_GRANT1;
          hlda1_d = 1'b1;
          sel_d   = SEL_CH1;
        end else if (!I_HRQ0 && !I_HRQ1) begin
          // Request withdrawn before the CPU let go: back off without a grant.
          state_d   = S_RELEASE;
          busrq_n_d = 1'b1;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc >= TMO_LIMIT) begin
            err_d = 1'b1;
          end
        end
      end

      S_GRANT0: begin
        if (!I_HRQ0) begin
          state_d   = S_RELEASE;
          hlda0_d   = 1'b0;
          sel_d     = SEL_CPU;
          busrq_n_d = 1'b1;
        end
      end

      S_GRANT1: begin
        if (!I_HRQ1) begin
          state_d   = S_RELEASE;
          hlda1_d   = 1'b0;
          sel_d     = SEL_CPU;
          busrq_n_d = 1'b1;
        end
      end

      S_RELEASE: begin
        // Wait for the Z80 to take the bus back before starting the gap.
        if (I_BUSAK_n) begin
          if (CPU_GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end

      S_GAP: begin
        // Requests are deliberately ignored here; they are picked up in IDLE.
        gap_d = gap_dec;
        if (gap_dec == '0) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        busrq_n_d = 1'b1;
        hlda0_d   = 1'b0;
        hlda1_d   = 1'b0;
        sel_d     = SEL_CPU;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      gap_q     <= '0;
      busrq_n_q <= 1'b1;
      hlda0_q   <= 1'b0;
      hlda1_q   <= 1'b0;
      sel_q     <= SEL_CPU;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (I_CLK_EN) begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      busrq_n_q <= busrq_n_d;
      hlda0_q   <= hlda0_d;
      hlda1_q   <= hlda1_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign O_BUSRQ_n = busrq_n_q;
  assign O_HLDA0   = hlda0_q;
  assign O_HLDA1   = hlda1_q;
  assign O_SEL     = sel_q;
  assign O_BUSY    = busy_q;
  assign O_ERR     = err_q;

  // Structural guarantees of the grant encoding.
  a_one_hlda : assert property (@(posedge I_CLK) disable iff (I_RST)
    !(hlda0_q && hlda1_q));
  a_sel_hlda : assert property (@(posedge I_CLK) disable iff (I_RST)
    ((sel_q != SEL_CPU) == (hlda0_q || hlda1_q)) && (sel_q != 2'b11));
  a_hlda_rq  : assert property (@(posedge I_CLK) disable iff (I_RST)
    (hlda0_q || hlda1_q) |-> !busrq_n_q);

endmodule

// File: tb/tb_dkong_bus_arb.sv
// tb/tb_dkong_bus_arb.sv - self-checking bench for dkong_bus_arb
module tb_dkong_bus_arb;

  logic       I_CLK = 1'b0;
  logic       I_RST = 1'b1;
  logic       I_CLK_EN = 1'b1;
  logic       I_HRQ0 = 1'b0;
  logic       I_HRQ1 = 1'b0;
  logic       I_BUSAK_n = 1'b1;
  logic       O_BUSRQ_n;
  logic       O_HLDA0;
  logic       O_HLDA1;
  logic [1:0] O_SEL;
  logic       O_BUSY;
  logic       O_ERR;

  dkong_bus_arb #(.CPU_GAP(4), .ACK_TIMEOUT(255)) dut (
    .I_CLK     (I_CLK),
    .I_RST     (I_RST),
    .I_CLK_EN  (I_CLK_EN),
    .I_HRQ0    (I_HRQ0),
    .I_HRQ1    (I_HRQ1),
    .I_BUSAK_n (I_BUSAK_n),
    .O_BUSRQ_n (O_BUSRQ_n),
    .O_HLDA0   (O_HLDA0),
    .O_HLDA1   (O_HLDA1),
    .O_SEL     (O_SEL),
    .O_BUSY    (O_BUSY),
    .O_ERR     (O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct {
    logic       rst, en, h0, h1, bk;
    logic       rq, a0, a1;
    logic [1:0] sel;
    logic       busy, err;
  } vec_t;

  typedef struct {
    logic       rq, a0, a1;
    logic [1:0] sel;
    logic       busy, err;
    int         idx;
  } exp_t;

  exp_t sb[$];
  vec_t tab[$];
  vec_t stall_tab[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;
  logic inv_on = 1'b0;

  function automatic vec_t mk(input logic rst, en, h0, h1, bk, rq, a0, a1,
                              input logic [1:0] sel, input logic busy, err);
    vec_t v;
    v.rst = rst; v.en = en; v.h0 = h0; v.h1 = h1; v.bk = bk;
    v.rq = rq; v.a0 = a0; v.a1 = a1; v.sel = sel; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      checks++;
      $display("FAIL %s: scoreboard empty at step %0d", tag, step_no);
    end else begin
      e = sb.pop_front();
      checks++;
      if (O_BUSRQ_n !== e.rq || O_HLDA0 !== e.a0 || O_HLDA1 !== e.a1 ||
          O_SEL !== e.sel || O_BUSY !== e.busy || O_ERR !== e.err) begin
        failures++;
        $display("FAIL %s step %0d: got busrq_n=%b hlda0=%b hlda1=%b sel=%b busy=%b err=%b, expected busrq_n=%b hlda0=%b hlda1=%b sel=%b busy=%b err=%b",
                 tag, e.idx, O_BUSRQ_n, O_HLDA0, O_HLDA1, O_SEL, O_BUSY, O_ERR,
                 e.rq, e.a0, e.a1, e.sel, e.busy, e.err);
      end
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    I_RST     = v.rst;
    I_CLK_EN  = v.en;
    I_HRQ0    = v.h0;
    I_HRQ1    = v.h1;
    I_BUSAK_n = v.bk;
    step_no++;
    e.rq = v.rq; e.a0 = v.a0; e.a1 = v.a1; e.sel = v.sel;
    e.busy = v.busy; e.err = v.err; e.idx = step_no;
    sb.push_back(e);
    @(posedge I_CLK);
    #1;
    check(tag);
  endtask

  // Grant-encoding invariants, sampled mid-cycle.
  always @(negedge I_CLK) begin
    if (inv_on) begin
      checks++;
      if ((O_HLDA0 && O_HLDA1) || ((O_SEL != 2'b00) != (O_HLDA0 || O_HLDA1)) ||
          (O_SEL == 2'b11) || ((O_HLDA0 || O_HLDA1) && O_BUSRQ_n)) begin
        failures++;
        $display("FAIL invariant t=%0t: hlda0=%b hlda1=%b sel=%b busrq_n=%b",
                 $time, O_HLDA0, O_HLDA1, O_SEL, O_BUSRQ_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t prev;

    // rst en h0 h1 bk | rq a0 a1 sel busy err
    // Single ch0 transaction.
    tab.push_back(mk(1,1,0,0,1, 1,0,0,2'b00,0,0));
    tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,0,0));
    tab.push_back(mk(0,1,1,0,1, 0,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,1,0,1, 0,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,1,0,1, 0,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,1,0,0, 0,1,0,2'b01,1,0));
    tab.push_back(mk(0,1,1,0,0, 0,1,0,2'b01,1,0));
    tab.push_back(mk(0,1,0,0,0, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,0,0, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,0,0));
    // Simultaneous requests: ch0 first, ch1 after release + gap.
    tab.push_back(mk(0,1,1,1,1, 0,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,1,1,0, 0,1,0,2'b01,1,0));
    tab.push_back(mk(0,1,1,1,0, 0,1,0,2'b01,1,0));
    tab.push_back(mk(0,1,0,1,0, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,1,1, 1,0,0,2'b00,1,0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(0,1,0,1,1, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,1,1, 1,0,0,2'b00,0,0));
    tab.push_back(mk(0,1,0,1,1, 0,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,1,0, 0,0,1,2'b10,1,0));
    tab.push_back(mk(0,1,0,0,0, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,0,0));
    // Withdrawn ch1 request, BUSAK never falls.
    tab.push_back(mk(0,1,0,1,1, 0,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,1,1, 0,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,0,0));

    // ch0 transaction with a same-channel re-request held off during GAP.
    stall_tab.push_back(mk(0,1,1,0,1, 0,0,0,2'b00,1,0));
    stall_tab.push_back(mk(0,1,1,0,1, 0,0,0,2'b00,1,0));
    stall_tab.push_back(mk(0,1,1,0,0, 0,1,0,2'b01,1,0));
    stall_tab.push_back(mk(0,1,0,0,0, 1,0,0,2'b00,1,0));
    stall_tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    for (int i = 0; i < 3; i++) stall_tab.push_back(mk(0,1,1,0,1, 1,0,0,2'b00,1,0));
    stall_tab.push_back(mk(0,1,1,0,1, 1,0,0,2'b00,0,0));
    stall_tab.push_back(mk(0,1,1,0,1, 0,0,0,2'b00,1,0));
    stall_tab.push_back(mk(0,1,1,0,0, 0,1,0,2'b01,1,0));
    stall_tab.push_back(mk(0,1,0,0,0, 1,0,0,2'b00,1,0));
    stall_tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    for (int i = 0; i < 3; i++) stall_tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,1,0));
    stall_tab.push_back(mk(0,1,0,0,1, 1,0,0,2'b00,0,0));

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i], "vector");
      inv_on = 1'b1;
    end

    // Clock enable high only every third edge; disabled edges see junk inputs.
    prev = mk(0,1,0,0,1, 1,0,0,2'b00,0,0);
    for (int i = 0; i < stall_tab.size(); i++) begin
      for (int k = 0; k < 2; k++) begin
        v = prev;
        v.en = 1'b0;
        v.h0 = 1'($urandom_range(0, 1));
        v.h1 = 1'($urandom_range(0, 1));
        v.bk = 1'($urandom_range(0, 1));
        step(v, "stall_hold");
      end
      step(stall_tab[i], "stall_step");
      prev = stall_tab[i];
    end

    // BUSAK timeout: error exactly on the 255th REQ edge, BUSRQ stays low.
    step(mk(0,1,1,0,1, 0,0,0,2'b00,1,0), "tmo_enter");
    for (int i = 1; i < 300; i++) begin
      step(mk(0,1,1,0,1, 0,0,0,2'b00,1,(i >= 255)), "tmo_wait");
    end
    step(mk(0,1,1,0,0, 0,1,0,2'b01,1,1), "tmo_grant");
    step(mk(0,1,0,0,0, 1,0,0,2'b00,1,1), "tmo_release");
    step(mk(0,1,0,0,1, 1,0,0,2'b00,1,1), "tmo_gap");
    for (int i = 0; i < 3; i++) step(mk(0,1,0,0,1, 1,0,0,2'b00,1,1), "tmo_gap");
    step(mk(0,1,0,0,1, 1,0,0,2'b00,0,1), "tmo_idle");

    // Reset mid-grant on channel 1 with the clock enable low.
    step(mk(0,1,0,1,1, 0,0,0,2'b00,1,1), "rst_req");
    step(mk(0,1,0,1,0, 0,0,1,2'b10,1,1), "rst_grant1");
    step(mk(0,1,0,1,0, 0,0,1,2'b10,1,1), "rst_grant1_hold");
    step(mk(1,0,0,1,0, 1,0,0,2'b00,0,0), "rst_midgrant");
    step(mk(0,1,0,0,1, 1,0,0,2'b00,0,0), "rst_after");

    inv_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
